// File: rtl/instr_link_pkg.sv
// Shared definitions for the command/confirm/sync instruction link,
// used by both the transmit serializer and the receive side.
package instr_link_pkg;

    localparam int INSTR_W = 10;

    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_TURN = 2'b01;
    localparam logic [1:0] OP_PUSH = 2'b10;
    localparam logic [1:0] OP_PULL = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SETUP    = 2'b01,
        WAIT_ACK = 2'b10,
        WAIT_REL = 2'b11
    } link_state_t;

    function automatic logic even_parity(input logic [INSTR_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; both stages
// clear to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic q_r;

    // Metastability-filter chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= 1'b0;
            q_r    <= 1'b0;
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/instruction_serializer.sv
// Shifts a parallel instruction out MSB first over a four-phase
// command/confirm/sync handshake. Define INSTR_TX_PARITY_EN to append an even-parity bit.
module instruction_serializer
    import instr_link_pkg::*;
#(
    parameter int SETUP_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic               command,
    output logic               confirm,
    input  logic               sync,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int SETUP_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(SETUP_CYCLES - 1);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

`ifdef INSTR_TX_PARITY_EN
    localparam int N_BITS = INSTR_W + 1;
`else
    localparam int N_BITS = INSTR_W;
`endif
    localparam int IDX_W = $clog2(N_BITS);
    localparam logic [IDX_W-1:0] BIT_LAST = IDX_W'(N_BITS - 1);

    link_state_t          state_r, state_nxt_s;
    logic [INSTR_W-2:0]   shift_r, shift_nxt_s;
    logic [IDX_W-1:0]     bit_idx_r, bit_idx_nxt_s;
    logic [SETUP_W-1:0]   setup_cnt_r, setup_cnt_nxt_s;
    logic [TO_W-1:0]      to_cnt_r, to_cnt_nxt_s;
    logic                 command_r, command_nxt_s;
    logic                 confirm_r, confirm_nxt_s;
    logic                 busy_r, busy_nxt_s;
    logic                 done_r, done_nxt_s;
    logic                 error_r, error_nxt_s;
    logic                 sync_s;
    logic                 accept_s;
    logic                 setup_done_s;
    logic                 to_hit_s;
    logic                 abort_s;
    logic                 next_bit_s;

    sync_2ff u_sync_2ff (
        .clk   (clk),
        .reset (reset),
        .d     (sync),
        .q     (sync_s)
    );

    assign accept_s     = instr_valid && (state_r == IDLE);
    assign setup_done_s = (setup_cnt_r == SETUP_LAST);
    assign to_hit_s     = TO_EN && (to_cnt_r == TO_LAST);

`ifdef INSTR_TX_PARITY_EN
    logic parity_r;

    // Parity of the accepted word, sent as the extra bit after bit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_r <= 1'b0;
        end else if (accept_s) begin
            parity_r <= even_parity(instr_in);
        end else begin
            parity_r <= parity_r;
        end
    end

    assign next_bit_s = (bit_idx_r == IDX_W'(INSTR_W - 1)) ? parity_r : shift_r[INSTR_W-2];
`else
    assign next_bit_s = shift_r[INSTR_W-2];
`endif

    // Next-state and next-output decode for the handshake FSM.
    always_comb begin
        state_nxt_s     = state_r;
        shift_nxt_s     = shift_r;
        bit_idx_nxt_s   = bit_idx_r;
        setup_cnt_nxt_s = setup_cnt_r;
        command_nxt_s   = command_r;
        confirm_nxt_s   = confirm_r;
        busy_nxt_s      = busy_r;
        done_nxt_s      = 1'b0;
        error_nxt_s     = 1'b0;
        abort_s         = 1'b0;

        case (state_r)
            IDLE: begin
                command_nxt_s = 1'b0;
                confirm_nxt_s = 1'b0;
                busy_nxt_s    = 1'b0;
                if (accept_s) begin
                    state_nxt_s     = SETUP;
                    shift_nxt_s     = instr_in[INSTR_W-2:0];
                    bit_idx_nxt_s   = {IDX_W{1'b0}};
                    setup_cnt_nxt_s = {SETUP_W{1'b0}};
                    command_nxt_s   = instr_in[INSTR_W-1];
                    busy_nxt_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETUP: begin
                // A receiver still holding sync from the previous bit blocks confirm.
                if (setup_done_s && !sync_s) begin
                    state_nxt_s   = WAIT_ACK;
                    confirm_nxt_s = 1'b1;
                end else if (to_hit_s) begin
                    abort_s = 1'b1;
                end else if (!setup_done_s) begin
                    setup_cnt_nxt_s = setup_cnt_r + SETUP_W'(1);
                end else begin
                    setup_cnt_nxt_s = setup_cnt_r;
                end
            end
            WAIT_ACK: begin
                if (sync_s) begin
                    state_nxt_s   = WAIT_REL;
                    confirm_nxt_s = 1'b0;
                end else if (to_hit_s) begin
                    abort_s = 1'b1;
                end else begin
                    confirm_nxt_s = 1'b1;
                end
            end
            WAIT_REL: begin
                if (!sync_s) begin
                    if (bit_idx_r == BIT_LAST) begin
                        state_nxt_s   = IDLE;
                        done_nxt_s    = 1'b1;
                        busy_nxt_s    = 1'b0;
                        command_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s     = SETUP;
                        bit_idx_nxt_s   = bit_idx_r + IDX_W'(1);
                        shift_nxt_s     = {shift_r[INSTR_W-3:0], 1'b0};
                        command_nxt_s   = next_bit_s;
                        setup_cnt_nxt_s = {SETUP_W{1'b0}};
                    end
                end else if (to_hit_s) begin
                    abort_s = 1'b1;
                end else begin
                    confirm_nxt_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                command_nxt_s = 1'b0;
                confirm_nxt_s = 1'b0;
                busy_nxt_s    = 1'b0;
            end
        endcase

        if (abort_s) begin
            state_nxt_s   = IDLE;
            error_nxt_s   = 1'b1;
            confirm_nxt_s = 1'b0;
            command_nxt_s = 1'b0;
            busy_nxt_s    = 1'b0;
        end else begin
            error_nxt_s = 1'b0;
        end

        // Timeout window restarts on every state entry.
        if ((state_nxt_s != state_r) || (state_r == IDLE)) begin
            to_cnt_nxt_s = {TO_W{1'b0}};
        end else begin
            to_cnt_nxt_s = to_cnt_r + TO_W'(1);
        end
    end

    // State and registered-output update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            shift_r     <= {(INSTR_W-1){1'b0}};
            bit_idx_r   <= {IDX_W{1'b0}};
            setup_cnt_r <= {SETUP_W{1'b0}};
            to_cnt_r    <= {TO_W{1'b0}};
            command_r   <= 1'b0;
            confirm_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            shift_r     <= shift_nxt_s;
            bit_idx_r   <= bit_idx_nxt_s;
            setup_cnt_r <= setup_cnt_nxt_s;
            to_cnt_r    <= to_cnt_nxt_s;
            command_r   <= command_nxt_s;
            confirm_r   <= confirm_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            error_r     <= error_nxt_s;
        end
    end

    assign instr_ready = (state_r == IDLE) && !reset;
    assign command     = command_r;
    assign confirm     = confirm_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign error       = error_r;

endmodule

// File: tb/tb_instruction_serializer.sv
// Directed self-checking bench for instruction_serializer with a
// behavioural receiver that acks/releases 3 cycles after confirm edges.
module tb_instruction_serializer;

`ifdef INSTR_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk;
    logic       reset;
    logic [9:0] instr_in;
    logic       instr_valid;
    logic       instr_ready;
    logic       command;
    logic       confirm;
    logic       sync;
    logic       busy;
    logic       done;
    logic       error;

    int vectors;
    int miscompares;

    // responder mode: 0 = hold sync low, 1 = normal receiver, 2 = hold sync high
    int mode;
    int dly;

    int rises;
    int n_done;
    int n_err;
    int n_both;
    logic conf_q;
    bit cmd_log[$];

    instruction_serializer #(
        .SETUP_CYCLES   (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .command     (command),
        .confirm     (confirm),
        .sync        (sync),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver model driving sync just after each rising edge.
    initial begin
        sync = 1'b0;
        dly  = 0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                1: begin
                    if (confirm && !sync) begin
                        dly++;
                        if (dly >= 3) begin sync = 1'b1; dly = 0; end
                    end else if (!confirm && sync) begin
                        dly++;
                        if (dly >= 3) begin sync = 1'b0; dly = 0; end
                    end else begin
                        dly = 0;
                    end
                end
                2: begin sync = 1'b1; dly = 0; end
                default: begin sync = 1'b0; dly = 0; end
            endcase
        end
    end

    // Link monitor: logs command at each confirm rise and counts pulses.
    initial begin
        rises = 0; n_done = 0; n_err = 0; n_both = 0; conf_q = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (confirm === 1'b1 && conf_q !== 1'b1) begin
                cmd_log.push_back(command);
                rises++;
            end
            conf_q = confirm;
            if (done === 1'b1) n_done++;
            if (error === 1'b1) n_err++;
            if (done === 1'b1 && error === 1'b1) n_both++;
        end
    end

    task automatic send_word(input logic [9:0] w, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (instr_ready === 1'b1) begin ok = 1'b1; break; end
        end
        if (ok) begin
            instr_in    = w;
            instr_valid = 1'b1;
            @(negedge clk);
            instr_valid = 1'b0;
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({instr_ready, command, confirm, busy, done, error} !== 6'b000000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {instr_ready, command, confirm, busy, done, error});
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b expected 1", instr_ready);
        end
    endtask

    task automatic test_basic;
        logic [9:0] w;
        bit ok;
        int r0, d0, e0, base;
        w = 10'b1011000011;
        mode = 1;
        r0 = rises; d0 = n_done; e0 = n_err; base = cmd_log.size();
        send_word(w, ok);
        if (ok) wait_done(ok);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_done_seen: got %b expected 1", ok);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (rises - r0 !== NB) begin
            miscompares++;
            $display("FAIL basic_pulses: got %0d expected %0d", rises - r0, NB);
        end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (cmd_log.size() <= base + i || cmd_log[base + i] !== w[9 - i]) begin
                miscompares++;
                $display("FAIL basic_bit%0d: got %b expected %b", i,
                         (cmd_log.size() > base + i) ? cmd_log[base + i] : 1'bx, w[9 - i]);
            end
        end
`ifdef INSTR_TX_PARITY_EN
        vectors++;
        if (cmd_log.size() <= base + 10 || cmd_log[base + 10] !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_parity_bit: got %b expected 1",
                     (cmd_log.size() > base + 10) ? cmd_log[base + 10] : 1'bx);
        end
`endif
        vectors++;
        if (n_done - d0 !== 1 || n_err - e0 !== 0) begin
            miscompares++;
            $display("FAIL basic_done_err: done %0d err %0d expected 1 0", n_done - d0, n_err - e0);
        end
        vectors++;
        if ({busy, instr_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL basic_idle: busy/ready %b expected 01", {busy, instr_ready});
        end
    endtask

    task automatic test_timeout;
        bit ok;
        int cnt, d0;
        mode = 0;
        d0 = n_done;
        send_word(10'b1111100000, ok);
        cnt = 0;
        while (confirm !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
        vectors++;
        if (confirm !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_confirm: got %b expected 1", confirm);
        end
        cnt = 0;
        while (error !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
        vectors++;
        if (cnt !== 64) begin
            miscompares++;
            $display("FAIL timeout_latency: got %0d expected 64", cnt);
        end
        vectors++;
        if ({confirm, busy, instr_ready, done} !== 4'b0010) begin
            miscompares++;
            $display("FAIL timeout_abort: confirm/busy/ready/done %b expected 0010",
                     {confirm, busy, instr_ready, done});
        end
        @(negedge clk);
        vectors++;
        if (error !== 1'b0 || n_done !== d0) begin
            miscompares++;
            $display("FAIL timeout_pulse: error %b done_delta %0d expected 0 0", error, n_done - d0);
        end
    endtask

    task automatic test_reset_mid;
        logic [9:0] w;
        bit ok;
        int cnt, r0, d0, base;
        mode = 1;
        r0 = rises; d0 = n_done;
        send_word(10'b1100101011, ok);
        cnt = 0;
        while (rises - r0 < 5 && cnt < 2000) begin @(negedge clk); cnt++; end
        vectors++;
        if (rises - r0 !== 5 || confirm !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_reach_bit4: pulses %0d confirm %b expected 5 1", rises - r0, confirm);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({command, confirm, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL rstmid_outputs: got %b expected 000", {command, confirm, busy});
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_ready: got %b expected 1", instr_ready);
        end
        w = 10'b0100000001;
        base = cmd_log.size();
        r0 = rises;
        send_word(w, ok);
        if (ok) wait_done(ok);
        vectors++;
        if (ok !== 1'b1 || n_done - d0 !== 1 || rises - r0 !== NB) begin
            miscompares++;
            $display("FAIL rstmid_resend: done_seen %b done_delta %0d pulses %0d expected 1 1 %0d",
                     ok, n_done - d0, rises - r0, NB);
        end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (cmd_log.size() <= base + i || cmd_log[base + i] !== w[9 - i]) begin
                miscompares++;
                $display("FAIL rstmid_bit%0d: expected %b", i, w[9 - i]);
            end
        end
`ifdef INSTR_TX_PARITY_EN
        vectors++;
        if (cmd_log.size() <= base + 10 || cmd_log[base + 10] !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_parity_bit: expected 0");
        end
`endif
    endtask

    task automatic test_back_to_back;
        logic [9:0] wa, wb;
        bit ok;
        int cnt, r0, d0, e0, base;
        wa = 10'b1100110101;
        wb = 10'b0011001010;
        mode = 1;
        r0 = rises; d0 = n_done; e0 = n_err; base = cmd_log.size();
        cnt = 0;
        while (instr_ready !== 1'b1 && cnt < 100) begin @(negedge clk); cnt++; end
        instr_in    = wa;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_in = wb;
        wait_done(ok);
        vectors++;
        if (ok !== 1'b1 || instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first_done: done_seen %b ready %b expected 1 1", ok, instr_ready);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || command !== wb[9]) begin
            miscompares++;
            $display("FAIL b2b_second_accept: busy %b command %b expected 1 %b", busy, command, wb[9]);
        end
        instr_valid = 1'b0;
        wait_done(ok);
        repeat (2) @(negedge clk);
        vectors++;
        if (ok !== 1'b1 || n_done - d0 !== 2 || n_err - e0 !== 0 || rises - r0 !== 2 * NB) begin
            miscompares++;
            $display("FAIL b2b_counts: done %0d err %0d pulses %0d expected 2 0 %0d",
                     n_done - d0, n_err - e0, rises - r0, 2 * NB);
        end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (cmd_log.size() <= base + NB + i || cmd_log[base + i] !== wa[9 - i]
                || cmd_log[base + NB + i] !== wb[9 - i]) begin
                miscompares++;
                $display("FAIL b2b_bit%0d: expected A %b B %b", i, wa[9 - i], wb[9 - i]);
            end
        end
    endtask

    task automatic test_sync_held;
        logic [9:0] w;
        bit ok;
        int cnt, r0, base;
        w = 10'b0110100101;
        mode = 2;
        repeat (4) @(negedge clk);
        r0 = rises; base = cmd_log.size();
        send_word(w, ok);
        repeat (20) @(negedge clk);
        vectors++;
        if (rises !== r0 || confirm !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL held_no_confirm: pulses %0d confirm %b busy %b expected 0 0 1",
                     rises - r0, confirm, busy);
        end
        mode = 0;
        cnt = 0;
        while (confirm !== 1'b1 && cnt < 50) begin @(negedge clk); cnt++; end
        vectors++;
        if (cnt !== 4) begin
            miscompares++;
            $display("FAIL held_release_latency: got %0d expected 4", cnt);
        end
        mode = 1;
        wait_done(ok);
        vectors++;
        if (ok !== 1'b1 || rises - r0 !== NB) begin
            miscompares++;
            $display("FAIL held_complete: done_seen %b pulses %0d expected 1 %0d", ok, rises - r0, NB);
        end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (cmd_log.size() <= base + i || cmd_log[base + i] !== w[9 - i]) begin
                miscompares++;
                $display("FAIL held_bit%0d: expected %b", i, w[9 - i]);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mode        = 0;
        reset       = 1'b1;
        instr_in    = 10'b0000000000;
        instr_valid = 1'b0;
        test_reset();
        test_basic();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_sync_held();
        vectors++;
        if (n_both !== 0) begin
            miscompares++;
            $display("FAIL done_error_overlap: got %0d expected 0", n_both);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
